// File: rtl/sysid_check_ctrl_pkg.sv
// Shared definitions for the system-ID check controller and the sysid generator scripts.
package sysid_pkg;
    typedef enum logic [2:0] {
        IDLE, START_PEND, RD_ID, RD_TS, COMPARE, FAIL
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] SYSID_EXPECTED_TIMESTAMP = 32'd1390219128;
endpackage

// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read-only bus between the check controller and the sysid slave.
interface sysid_check_ctrl_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
    modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/sysid_check_ctrl_stall_timer.sv
// 8-bit clearable stall counter; terminal flags that LIMIT stall cycles have been counted.
module sysid_stall_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic stall,
    output logic terminal
);
    logic [7:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   count <= 8'd0;
        else if (clear) count <= 8'd0;
        else if (stall) count <= count + 8'd1;
    end

    assign terminal = (count == 8'(LIMIT));
endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads sysid ID and timestamp words, compares against build constants, reports status.
module sysid_check_ctrl
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_EXPECTED_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    sysid_check_ctrl_if.master  avm,
    output logic                busy,
    output logic                done,
    output logic                sys_ok,
    output logic                id_mismatch,
    output logic                ts_mismatch,
    output logic                timeout_err,
    output logic [31:0]         captured_id,
    output logic [31:0]         captured_ts,
    output logic [1:0]          retry_count
);
    localparam state_t     RST_STATE = AUTO_START ? START_PEND : IDLE;
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

    state_t state, state_nx;
    logic   reading, granted, stall_max, timeout, accept;

    assign reading = (state == RD_ID) || (state == RD_TS);
    assign granted = reading && !avm.avm_waitrequest;
    assign timeout = reading && avm.avm_waitrequest && stall_max;
    assign accept  = (state == IDLE) && start;

    sysid_stall_timer #(.LIMIT(TIMEOUT_CYCLES)) u_stall (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (!reading || granted),
        .stall    (avm.avm_waitrequest),
        .terminal (stall_max)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RST_STATE;
        else          state <= state_nx;
    end

    // A timeout backs off through START_PEND so avm_read drops for one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (start) state_nx = RD_ID;
            START_PEND: state_nx = RD_ID;
            RD_ID, RD_TS: begin
                if (granted)      state_nx = (state == RD_ID) ? RD_TS : COMPARE;
                else if (timeout) state_nx = (retry_count == RETRY_MAX) ? FAIL : START_PEND;
            end
            COMPARE:    state_nx = IDLE;
            FAIL:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    assign avm.avm_read    = reading;
    assign avm.avm_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign done            = (state == COMPARE) || (state == FAIL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            sys_ok      <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout_err <= 1'b0;
            retry_count <= 2'd0;
            captured_id <= 32'd0;
            captured_ts <= 32'd0;
        end else begin
            busy <= (state_nx != IDLE);
            if (accept) begin
                sys_ok      <= 1'b0;
                id_mismatch <= 1'b0;
                ts_mismatch <= 1'b0;
                timeout_err <= 1'b0;
                retry_count <= 2'd0;
            end
            if (timeout && retry_count != RETRY_MAX) retry_count <= retry_count + 2'd1;
            if (granted && state == RD_ID) captured_id <= avm.avm_readdata;
            if (granted && state == RD_TS) captured_ts <= avm.avm_readdata;
            if (state == COMPARE) begin
                sys_ok      <= (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TIMESTAMP);
                id_mismatch <= (captured_id != EXPECTED_ID);
                ts_mismatch <= (captured_ts != EXPECTED_TIMESTAMP);
            end
            if (state == FAIL) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: per-cycle behavioural model plus literal checkpoints.
module tb_sysid_check_ctrl;
    import sysid_pkg::*;

    localparam int TO = 255;
    localparam int MR = 3;
    localparam logic [31:0] EID = SYSID_EXPECTED_ID;
    localparam logic [31:0] ETS = SYSID_EXPECTED_TIMESTAMP;

    logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic        slv_wr = 1'b0;
    logic [31:0] slv_id = EID, slv_ts = ETS;
    logic        busy, done, sys_ok, id_mismatch, ts_mismatch, timeout_err;
    logic [31:0] captured_id, captured_ts;
    logic [1:0]  retry_count;

    int n_cmp = 0, n_bad = 0;
    int n_done = 0, n_id_rd = 0, n_rd_cyc = 0;

    sysid_check_ctrl_if avm();
    assign avm.avm_readdata    = avm.avm_address ? slv_ts : slv_id;
    assign avm.avm_waitrequest = slv_wr;

    sysid_check_ctrl #(
        .EXPECTED_ID(EID), .EXPECTED_TIMESTAMP(ETS),
        .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .AUTO_START(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .avm(avm),
        .busy(busy), .done(done), .sys_ok(sys_ok), .id_mismatch(id_mismatch),
        .ts_mismatch(ts_mismatch), .timeout_err(timeout_err),
        .captured_id(captured_id), .captured_ts(captured_ts), .retry_count(retry_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: what a check must look like on the bus and in the status outputs.
    bit          m_active, m_gap;
    int          m_word, m_stall, m_retry, m_fin;
    bit          e_busy, e_ok, e_idm, e_tsm, e_to;
    logic [31:0] e_cid, e_cts;

    task automatic m_reset();
        m_active = 1; m_gap = 1; m_word = 0; m_stall = 0; m_retry = 0; m_fin = 0;
        e_busy = 0; e_ok = 0; e_idm = 0; e_tsm = 0; e_to = 0; e_cid = 0; e_cts = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clock);
            if (!reset_n) m_reset();
            check("done", done, 32'(m_fin != 0));
            check("busy", busy, 32'(e_busy));
            check("read", avm.avm_read, 32'(m_active && !m_gap && m_fin == 0));
            if (avm.avm_read) check("addr", avm.avm_address, 32'(m_word));
            check("sys_ok", sys_ok, 32'(e_ok));
            check("id_mm", id_mismatch, 32'(e_idm));
            check("ts_mm", ts_mismatch, 32'(e_tsm));
            check("to_err", timeout_err, 32'(e_to));
            check("cap_id", captured_id, e_cid);
            check("cap_ts", captured_ts, e_cts);
            check("retry", retry_count, 32'(m_retry));
            n_done   += int'(done);
            n_rd_cyc += int'(avm.avm_read);
            n_id_rd  += int'(avm.avm_read && !slv_wr && !avm.avm_address);
            if (reset_n) begin
                if (m_fin != 0) begin
                    if (m_fin == 1) begin
                        e_ok = (e_cid == EID) && (e_cts == ETS);
                        e_idm = (e_cid != EID); e_tsm = (e_cts != ETS);
                    end else e_to = 1;
                    m_fin = 0; m_active = 0; e_busy = 0;
                end else if (!m_active) begin
                    if (start) begin
                        m_active = 1; m_gap = 0; m_word = 0; m_stall = 0; m_retry = 0;
                        e_ok = 0; e_idm = 0; e_tsm = 0; e_to = 0; e_busy = 1;
                    end
                end else if (m_gap) begin
                    m_gap = 0; m_word = 0; m_stall = 0; e_busy = 1;
                end else if (!slv_wr) begin
                    if (m_word == 0) begin e_cid = slv_id; m_word = 1; m_stall = 0; end
                    else begin e_cts = slv_ts; m_fin = 1; end
                end else if (m_stall == TO) begin
                    m_stall = 0;
                    if (m_retry == MR) m_fin = 2;
                    else begin m_retry++; m_gap = 1; end
                end else m_stall++;
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        while (!done && k < budget) begin tick(); k++; end
        check(nm, done, 1);
    endtask

    int snap, snap2;

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_read", avm.avm_read, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;

        // Zero-wait auto-start: done on the third edge after release
        repeat (2) tick();
        check("lat_early", done, 0);
        tick();
        check("lat_done", done, 1);
        tick();
        check("t1_ok", sys_ok, 1);
        check("t1_retry", retry_count, 0);

        // ID mismatch is final, no retry
        slv_id = 32'h1; snap = n_id_rd;
        pulse_start();
        wait_done("t2_wait", 20);
        tick();
        check("t2_idm", id_mismatch, 1);
        check("t2_ok", sys_ok, 0);
        check("t2_cap", captured_id, 32'h1);
        check("t2_idreads", n_id_rd - snap, 1);

        // 300-cycle stall in the timestamp read forces one retry and an ID re-read
        slv_id = EID; snap = n_id_rd;
        pulse_start();
        begin
            int k = 0;
            while (!(avm.avm_read && avm.avm_address) && k < 20) begin tick(); k++; end
            check("t3_ts_seen", avm.avm_read && avm.avm_address, 1);
        end
        slv_wr = 1'b1;
        repeat (300) tick();
        slv_wr = 1'b0;
        wait_done("t3_wait", 400);
        tick();
        check("t3_retry", retry_count, 1);
        check("t3_ok", sys_ok, 1);
        check("t3_idreads", n_id_rd - snap, 2);

        // Slave stuck: four attempts of 256 read cycles, then give up
        slv_wr = 1'b1; snap = n_rd_cyc;
        pulse_start();
        wait_done("t4_wait", 1500);
        check("t4_rdcyc", n_rd_cyc - snap, 1024);
        tick();
        check("t4_to", timeout_err, 1);
        check("t4_retry", retry_count, 3);
        check("t4_busy", busy, 0);

        // start while busy and during done is dropped; start two cycles after done runs
        slv_wr = 1'b0; snap = n_done;
        pulse_start();
        tick();
        start = 1'b1;
        tick();
        check("t5_done", done, 1);
        tick();
        start = 1'b0;
        tick();
        check("t5_one", n_done - snap, 1);
        check("t5_idle", busy, 0);
        pulse_start();
        wait_done("t5_wait2", 20);
        tick();
        check("t5_two", n_done - snap, 2);

        // Asynchronous reset during a stalled ID read
        slv_wr = 1'b1;
        pulse_start();
        check("t6_reading", avm.avm_read, 1);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check("t6_read_drop", avm.avm_read, 0);
        check("t6_busy_drop", busy, 0);
        check("t6_cap_clr", captured_ts, 0);
        repeat (2) tick();
        slv_wr = 1'b0; reset_n = 1'b1;
        snap2 = n_done;
        repeat (3) tick();
        check("t6_done", done, 1);
        tick();
        check("t6_ok", sys_ok, 1);
        check("t6_ndone", n_done - snap2, 1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
